// File: rtl/ram_dp_sync_be.sv
// Synchronous true dual-port RAM with byte-lane writes, 1- or 2-cycle registered
// reads, same-address write/write flagging and a post-reset clearing sequencer.
//
// state    | meaning
// ST_INIT  | writing INIT_VALUE to mem[cnt_q]; port traffic is dropped
// ST_READY | normal dual-port operation
module ram_dp_sync_be #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int RAM_DEPTH  = 64,
  parameter int RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_0,
  input  logic                  we_0,
  input  logic [BE_WIDTH-1:0]   be_0,
  input  logic [ADDR_WIDTH-1:0] address_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic                  rvalid_0,
  input  logic                  cs_1,
  input  logic                  we_1,
  input  logic [BE_WIDTH-1:0]   be_1,
  input  logic [ADDR_WIDTH-1:0] address_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  rvalid_1,
  output logic                  init_busy,
  output logic                  collision
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic                       ready;
  logic [1:0]                 cs, we, in_rng, rd_req, wr_req;
  logic [1:0][BE_WIDTH-1:0]   be;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] wdata;
  logic [1:0]                 rv1_q;
  logic [1:0][DATA_WIDTH-1:0] rd1_q;
  logic [1:0]                 rvalid;
  logic [1:0][DATA_WIDTH-1:0] rdata;
  logic                       coll_q, coll_d;

  assign cs    = {cs_1, cs_0};
  assign we    = {we_1, we_0};
  assign be    = {be_1, be_0};
  assign addr  = {address_1, address_0};
  assign wdata = {wdata_1, wdata_0};
  assign ready = (state_q == ST_READY);

  always_comb begin
    in_rng = '0;
    rd_req = '0;
    wr_req = '0;
    for (int p = 0; p < 2; p++) begin
      in_rng[p] = ({1'b0, addr[p]} < DEPTH_EXT);
      rd_req[p] = ready && cs[p] && !we[p];
      wr_req[p] = ready && cs[p] && we[p] && in_rng[p];
    end
    coll_d = ready && cs[0] && we[0] && cs[1] && we[1] && (addr[0] == addr[1]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: ;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Port 1 lanes are applied first so port 0 overrides on a shared address.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= INIT_VALUE;
    end else begin
      for (int p = 1; p >= 0; p--) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (wr_req[p] && be[p][i]) mem_q[addr[p]][8*i +: 8] <= wdata[p][8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv1_q  <= '0;
      rd1_q  <= '0;
      coll_q <= 1'b0;
    end else begin
      rv1_q  <= rd_req;
      coll_q <= coll_d;
      for (int p = 0; p < 2; p++) begin
        if (rd_req[p]) rd1_q[p] <= in_rng[p] ? mem_q[addr[p]] : '0;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [1:0]                 rv2_q;
    logic [1:0][DATA_WIDTH-1:0] rd2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv2_q <= '0;
        rd2_q <= '0;
      end else begin
        rv2_q <= rv1_q;
        for (int p = 0; p < 2; p++) begin
          if (rv1_q[p]) rd2_q[p] <= rd1_q[p];
        end
      end
    end

    assign rvalid = rv2_q;
    assign rdata  = rd2_q;
  end else begin : g_lat1
    assign rvalid = rv1_q;
    assign rdata  = rd1_q;
  end

  assign rdata_0   = rdata[0];
  assign rdata_1   = rdata[1];
  assign rvalid_0  = rvalid[0];
  assign rvalid_1  = rvalid[1];
  assign init_busy = (state_q == ST_INIT);
  assign collision = coll_q;

endmodule

// File: tb/tb_ram_dp_sync_be.sv
// Bench for ram_dp_sync_be: two instances (64x16 latency 1, 100x16 latency 2)
// share stimulus and are compared against an array-based reference model.
module tb_ram_dp_sync_be;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cs_0, we_0, cs_1, we_1;
  logic [1:0]  be_0, be_1;
  logic [6:0]  addr_0, addr_1;
  logic [15:0] wdata_0, wdata_1;

  logic [1:0][15:0] rdata0_w, rdata1_w;
  logic [1:0]       rvalid0_w, rvalid1_w, busy_w, coll_w;

  ram_dp_sync_be #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .RAM_DEPTH(64), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .cs_0(cs_0), .we_0(we_0), .be_0(be_0), .address_0(addr_0[5:0]), .wdata_0(wdata_0),
    .rdata_0(rdata0_w[0]), .rvalid_0(rvalid0_w[0]),
    .cs_1(cs_1), .we_1(we_1), .be_1(be_1), .address_1(addr_1[5:0]), .wdata_1(wdata_1),
    .rdata_1(rdata1_w[0]), .rvalid_1(rvalid1_w[0]),
    .init_busy(busy_w[0]), .collision(coll_w[0]));

  ram_dp_sync_be #(.DATA_WIDTH(16), .ADDR_WIDTH(7), .RAM_DEPTH(100), .RD_LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cs_0(cs_0), .we_0(we_0), .be_0(be_0), .address_0(addr_0), .wdata_0(wdata_0),
    .rdata_0(rdata0_w[1]), .rvalid_0(rvalid0_w[1]),
    .cs_1(cs_1), .we_1(we_1), .be_1(be_1), .address_1(addr_1), .wdata_1(wdata_1),
    .rdata_1(rdata1_w[1]), .rvalid_1(rvalid1_w[1]),
    .init_busy(busy_w[1]), .collision(coll_w[1]));

  int depth [2] = '{64, 100};
  int lat   [2] = '{1, 2};
  int amask [2] = '{63, 127};

  logic [15:0] mm    [2][128];
  logic        hv    [2][2][4096];
  logic [15:0] hd    [2][2][4096];
  logic [15:0] lastd [2][2];
  logic        exp_coll [2];
  int k;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: reads see pre-write contents, port 1 lanes land first and
  // port 0 lanes overwrite them, out-of-range reads return 0.
  task automatic model_edge();
    int a0, a1;
    logic act;
    for (int d = 0; d < 2; d++) begin
      a0  = int'(addr_0) & amask[d];
      a1  = int'(addr_1) & amask[d];
      act = (k >= depth[d]);
      hv[d][0][k] = act && cs_0 && !we_0;
      hd[d][0][k] = (a0 < depth[d]) ? mm[d][a0] : 16'h0;
      hv[d][1][k] = act && cs_1 && !we_1;
      hd[d][1][k] = (a1 < depth[d]) ? mm[d][a1] : 16'h0;
      exp_coll[d] = act && cs_0 && we_0 && cs_1 && we_1 && (a0 == a1);
      if (act) begin
        for (int b = 0; b < 2; b++)
          if (cs_1 && we_1 && a1 < depth[d] && be_1[b]) mm[d][a1][8*b +: 8] = wdata_1[8*b +: 8];
        for (int b = 0; b < 2; b++)
          if (cs_0 && we_0 && a0 < depth[d] && be_0[b]) mm[d][a0][8*b +: 8] = wdata_0[8*b +: 8];
      end
    end
  endtask

  task automatic step();
    int idx;
    logic ev;
    logic [15:0] ed;
    for (int d = 0; d < 2; d++)
      check($sformatf("busy d%0d k%0d", d, k), 32'(busy_w[d]), 32'(k < depth[d]));
    model_edge();
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        idx = k - (lat[d] - 1);
        ev  = (idx >= 0) ? hv[d][p][idx] : 1'b0;
        ed  = (idx >= 0) ? hd[d][p][idx] : 16'h0;
        if (ev) lastd[d][p] = ed;
        check($sformatf("rvalid d%0d p%0d k%0d", d, p, k),
              32'((p == 0) ? rvalid0_w[d] : rvalid1_w[d]), 32'(ev));
        check($sformatf("rdata d%0d p%0d k%0d", d, p, k),
              32'((p == 0) ? rdata0_w[d] : rdata1_w[d]), 32'(lastd[d][p]));
      end
      check($sformatf("collision d%0d k%0d", d, k), 32'(coll_w[d]), 32'(exp_coll[d]));
    end
    k++;
  endtask

  task automatic op(input logic c0, input logic w0, input logic [1:0] b0, input int a0,
                    input logic [15:0] d0, input logic c1, input logic w1,
                    input logic [1:0] b1, input int a1, input logic [15:0] d1);
    cs_0 = c0; we_0 = w0; be_0 = b0; addr_0 = 7'(a0); wdata_0 = d0;
    cs_1 = c1; we_1 = w1; be_1 = b1; addr_1 = 7'(a1); wdata_1 = d1;
    step();
  endtask

  task automatic idle();
    op(0, 0, 2'b00, 0, 16'h0, 0, 0, 2'b00, 0, 16'h0);
  endtask

  // Called at a falling edge; checks the asynchronous clear, then releases.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst rdata0 d%0d", d), 32'(rdata0_w[d]), 32'h0);
      check($sformatf("rst rdata1 d%0d", d), 32'(rdata1_w[d]), 32'h0);
      check($sformatf("rst rvalid d%0d", d), 32'({rvalid1_w[d], rvalid0_w[d]}), 32'h0);
      check($sformatf("rst collision d%0d", d), 32'(coll_w[d]), 32'h0);
      check($sformatf("rst busy d%0d", d), 32'(busy_w[d]), 32'h1);
      for (int a = 0; a < 128; a++) mm[d][a] = 16'h0;
      lastd[d][0] = 16'h0;
      lastd[d][1] = 16'h0;
    end
    k = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    cs_0 = 0; we_0 = 0; be_0 = 0; addr_0 = 0; wdata_0 = 0;
    cs_1 = 0; we_1 = 0; be_1 = 0; addr_1 = 0; wdata_1 = 0;
    k = 0;
    @(negedge clk);
    apply_reset();

    // init with a read held on port 0 throughout, then sweep every address
    for (int i = 0; i < 100; i++) op(1, 0, 2'b00, i % 64, 16'h0, 0, 0, 2'b00, 0, 16'h0);
    for (int i = 0; i < 100; i++) op(1, 0, 2'b00, i, 16'h0, 1, 0, 2'b00, 99 - i, 16'h0);
    idle();

    // byte enables
    op(1, 1, 2'b11, 5, 16'hABCD, 0, 0, 2'b00, 0, 16'h0);
    op(1, 1, 2'b10, 5, 16'h1200, 0, 0, 2'b00, 0, 16'h0);
    op(0, 0, 2'b00, 0, 16'h0, 1, 0, 2'b11, 5, 16'h0);
    check("be lat1 rdata", 32'(rdata1_w[0]), 32'h12CD);
    check("be lat1 rvalid", 32'(rvalid1_w), 32'b01);
    idle();
    check("be lat2 rdata", 32'(rdata1_w[1]), 32'h12CD);
    check("be lat2 rvalid", 32'(rvalid1_w), 32'b10);

    // write/write collision
    op(1, 1, 2'b01, 9, 16'h1111, 1, 1, 2'b11, 9, 16'h2222);
    check("collision pulse", 32'(coll_w), 32'b11);
    idle();
    check("collision clear", 32'(coll_w), 32'b00);
    op(1, 0, 2'b00, 9, 16'h0, 0, 0, 2'b00, 0, 16'h0);
    idle();
    check("collision merge", 32'(rdata0_w), {16'h2211, 16'h2211});
    op(1, 1, 2'b11, 20, 16'h3333, 1, 1, 2'b11, 21, 16'h4444);
    op(1, 1, 2'b11, 20, 16'h5555, 1, 0, 2'b11, 20, 16'h0);
    check("no collision", 32'(coll_w), 32'b00);
    idle();

    // read-first across ports
    op(1, 1, 2'b11, 3, 16'h0055, 0, 0, 2'b00, 0, 16'h0);
    op(1, 1, 2'b11, 3, 16'h00AA, 1, 0, 2'b00, 3, 16'h0);
    idle();
    check("read-first old", 32'(rdata1_w), {16'h0055, 16'h0055});
    op(0, 0, 2'b00, 0, 16'h0, 1, 0, 2'b00, 3, 16'h0);
    idle();
    check("read-first new", 32'(rdata1_w), {16'h00AA, 16'h00AA});

    // out-of-range guard (depth-100 instance), boundary word, back-to-back reads
    op(1, 1, 2'b11, 120, 16'hFFFF, 1, 1, 2'b11, 99, 16'h9999);
    op(1, 1, 2'b11, 100, 16'hEEEE, 0, 0, 2'b00, 0, 16'h0);
    op(1, 0, 2'b00, 120, 16'h0, 1, 0, 2'b00, 99, 16'h0);
    idle();
    check("range rdata", 32'(rdata0_w[1]), 32'h0);
    check("range rvalid", 32'(rvalid0_w[1]), 32'h1);
    op(1, 0, 2'b00, 100, 16'h0, 0, 0, 2'b00, 0, 16'h0);
    for (int i = 0; i < 4; i++) op(0, 0, 2'b00, 0, 16'h0, 1, 1, 2'b11, i, 16'h1000 + 16'(i));
    for (int i = 0; i < 4; i++) op(1, 0, 2'b00, i, 16'h0, 0, 0, 2'b00, 0, 16'h0);
    idle();
    idle();

    // reset during a read pipeline, then mid-init at counter 30
    op(0, 0, 2'b00, 0, 16'h0, 1, 0, 2'b00, 5, 16'h0);
    apply_reset();
    for (int i = 0; i < 30; i++) idle();
    apply_reset();
    for (int i = 0; i < 100; i++) idle();
    op(1, 0, 2'b00, 5, 16'h0, 1, 0, 2'b00, 9, 16'h0);
    op(1, 0, 2'b00, 3, 16'h0, 1, 0, 2'b00, 2, 16'h0);
    idle();
    idle();

    // randomized traffic on a small address window to provoke collisions
    for (int i = 0; i < 400; i++)
      op(1'($urandom), 1'($urandom), 2'($urandom_range(1, 3)), $urandom_range(0, 15),
         16'($urandom), 1'($urandom), 1'($urandom), 2'($urandom_range(1, 3)),
         $urandom_range(0, 15), 16'($urandom));
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
